ahb_scratch_slave: RTL and testbench



---
 rtl/ahb_scratch_slave.sv | 184 ++++++++++++++++++
 tb/tb_ahb_scratch_slave.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ahb_scratch_slave.sv
// AHB-Lite scratchpad responder: register-file memory with programmable wait states,
// ERROR responses for bad transfers, and a doorbell interrupt from bit0 of the last word.
module ahb_scratch_slave #(
  parameter int DEPTH_LOG2  = 4,
  parameter int WAIT_STATES = 1
) (
  input  logic        hclk,
  input  logic        hrst_b,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [3:0]  hprot,
  input  logic [31:0] hwdata,
  input  logic        hreadyin,
  output logic [31:0] hrdata,
  output logic        hready,
  output logic [1:0]  hresp,
  output logic        intr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [1:0] WS_LAST = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic                  write_q, write_d;
  logic [3:0]            mask_q, mask_d;
  logic [1:0]            wait_cnt_q, wait_cnt_d;
  logic                  intr_q;
  logic [31:0]           mem_q [DEPTH];

  logic                  accept;
  logic                  range_err;
  logic                  size_err;
  logic                  align_err;
  logic                  xfer_err;
  logic [3:0]            lane_mask;
  logic                  do_write;
  logic [DEPTH-1:0]      word_we;
  logic                  unused_ok;

  assign unused_ok = ^{hprot, haddr[31:12], htrans[0]};

  // With the maximum depth every offset in the 4 KB slot maps to a word.
  generate
    if (DEPTH_LOG2 < 10) begin : g_range
      assign range_err = |haddr[11:DEPTH_LOG2+2];
    end else begin : g_full
      assign range_err = 1'b0;
    end
  endgenerate

  assign size_err  = (hsize > 3'd2);
  assign align_err = ((hsize == 3'd1) && haddr[0]) ||
                     ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
  assign xfer_err  = range_err | size_err | align_err;

  always_comb begin
    lane_mask = 4'b1111;
    case (hsize)
      3'd0:    lane_mask = 4'b0001 << haddr[1:0];
      3'd1:    lane_mask = haddr[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  end

  // Only states that present hready=1 may take a new address phase.
  assign accept = hsel && htrans[1] && hreadyin &&
                  ((state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2));

  always_ff @(posedge hclk or negedge hrst_b) begin
    if (!hrst_b) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      write_q    <= 1'b0;
      mask_q     <= 4'b0000;
      wait_cnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      write_q    <= write_d;
      mask_q     <= mask_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    write_d    = write_q;
    mask_d     = mask_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (accept) begin
          idx_d   = haddr[DEPTH_LOG2+1:2];
          write_d = hwrite;
          mask_d  = lane_mask;
          if (xfer_err) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d    = ST_WAIT;
            wait_cnt_d = WS_LAST;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == 2'd0) begin
          state_d = ST_DATA;
        end else begin
          wait_cnt_d = wait_cnt_q - 2'd1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    hready = 1'b1;
    hresp  = 2'b00;
    hrdata = '0;
    case (state_q)
      ST_WAIT: hready = 1'b0;
      ST_DATA: hrdata = mem_q[idx_q];
      ST_ERR1: begin
        hready = 1'b0;
        hresp  = 2'b01;
      end
      ST_ERR2: hresp = 2'b01;
      default: ;
    endcase
  end

  assign do_write = (state_q == ST_DATA) && write_q;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
      assign word_we[gi] = do_write && (idx_q == DEPTH_LOG2'(gi));
    end
  endgenerate

  always_ff @(posedge hclk or negedge hrst_b) begin
    if (!hrst_b) begin
      for (int w = 0; w < DEPTH; w++) begin
        mem_q[w] <= '0;
      end
    end else begin
      for (int w = 0; w < DEPTH; w++) begin
        for (int b = 0; b < 4; b++) begin
          if (word_we[w] && mask_q[b]) begin
            mem_q[w][8*b +: 8] <= hwdata[8*b +: 8];
          end
        end
      end
    end
  end

  // Doorbell follows the committed memory bit one cycle later.
  always_ff @(posedge hclk or negedge hrst_b) begin
    if (!hrst_b) begin
      intr_q <= 1'b0;
    end else begin
      intr_q <= mem_q[DEPTH-1][0];
    end
  end

  assign intr = intr_q;

endmodule

// File: tb/tb_ahb_scratch_slave.sv
// Directed bench for ahb_scratch_slave: one instance with one wait state and one
// zero-wait instance for pipelined back-to-back traffic.
module tb_ahb_scratch_slave;

  logic        hclk;
  logic        hrst_b;
  logic        hsel_w1, hsel_w0;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic [31:0] hrdata_w1, hrdata_w0;
  logic        hready_w1, hready_w0;
  logic [1:0]  hresp_w1, hresp_w0;
  logic        intr_w1, intr_w0;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] rd;
  int          wt;
  logic [1:0]  r0, rl;

  ahb_scratch_slave #(.DEPTH_LOG2(4), .WAIT_STATES(1)) dut_w1 (
    .hclk(hclk), .hrst_b(hrst_b), .hsel(hsel_w1), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hwdata(hwdata),
    .hreadyin(hready_w1), .hrdata(hrdata_w1), .hready(hready_w1), .hresp(hresp_w1),
    .intr(intr_w1)
  );

  ahb_scratch_slave #(.DEPTH_LOG2(4), .WAIT_STATES(0)) dut_w0 (
    .hclk(hclk), .hrst_b(hrst_b), .hsel(hsel_w0), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hwdata(hwdata),
    .hreadyin(hready_w0), .hrdata(hrdata_w0), .hready(hready_w0), .hresp(hresp_w0),
    .intr(intr_w0)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One non-pipelined transfer; returns at 1ns after the edge that ends its data phase.
  task automatic xfer(input bit use_w0, input logic wr, input logic [2:0] sz,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output int waits,
                      output logic [1:0] resp0, output logic [1:0] respl);
    int cyc;
    hsel_w1 = !use_w0;
    hsel_w0 = use_w0;
    haddr   = addr;
    htrans  = 2'b10;
    hwrite  = wr;
    hsize   = sz;
    @(posedge hclk); #1;
    hsel_w1 = 1'b0;
    hsel_w0 = 1'b0;
    htrans  = 2'b00;
    hwdata  = wdata;
    waits   = 0;
    cyc     = 0;
    resp0   = use_w0 ? hresp_w0 : hresp_w1;
    while (((use_w0 ? hready_w0 : hready_w1) !== 1'b1) && (cyc < 8)) begin
      waits++;
      @(posedge hclk); #1;
      cyc++;
    end
    respl = use_w0 ? hresp_w0 : hresp_w1;
    rdata = use_w0 ? hrdata_w0 : hrdata_w1;
    $display("xfer dut=%0d wr=%0b size=%0d addr=%h wdata=%h rdata=%h waits=%0d resp=%b/%b",
             use_w0 ? 0 : 1, wr, sz, addr, wdata, rdata, waits, resp0, respl);
    @(posedge hclk); #1;
  endtask

  initial begin
    hrst_b  = 1'b0;
    hsel_w1 = 1'b0;
    hsel_w0 = 1'b0;
    haddr   = '0;
    htrans  = 2'b00;
    hwrite  = 1'b0;
    hsize   = 3'd2;
    hprot   = 4'b0011;
    hwdata  = '0;
    repeat (3) @(posedge hclk);
    #1;
    chk("rst_hready", 32'(hready_w1), 32'd1);
    chk("rst_hresp", 32'(hresp_w1), 32'd0);
    chk("rst_hrdata", hrdata_w1, 32'd0);
    chk("rst_intr", 32'(intr_w1), 32'd0);
    hrst_b = 1'b1;
    @(posedge hclk); #1;

    // Doorbell set, so the reset test below can see it drop
    xfer(1'b0, 1'b1, 3'd2, 32'h03C, 32'h1, rd, wt, r0, rl);
    chk("db_intr_at_commit", 32'(intr_w1), 32'd0);
    @(posedge hclk); #1;
    chk("db_intr_set", 32'(intr_w1), 32'd1);

    // Reset mid-wait of a write to 0x004
    hsel_w1 = 1'b1; haddr = 32'h004; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
    @(posedge hclk); #1;
    hsel_w1 = 1'b0; htrans = 2'b00; hwdata = 32'hDEADBEEF;
    chk("midrst_in_wait", 32'(hready_w1), 32'd0);
    hrst_b = 1'b0;
    #1;
    chk("midrst_hready", 32'(hready_w1), 32'd1);
    chk("midrst_hresp", 32'(hresp_w1), 32'd0);
    chk("midrst_hrdata", hrdata_w1, 32'd0);
    chk("midrst_intr", 32'(intr_w1), 32'd0);
    $display("reset asserted mid-wait");
    repeat (2) @(posedge hclk);
    #1;
    hrst_b = 1'b1;
    @(posedge hclk); #1;
    xfer(1'b0, 1'b0, 3'd2, 32'h004, 32'h0, rd, wt, r0, rl);
    chk("midrst_read_004", rd, 32'h0);

    // Word write/read with one wait state
    xfer(1'b0, 1'b1, 3'd2, 32'h008, 32'h12345678, rd, wt, r0, rl);
    chk("ww_waits", 32'(wt), 32'd1);
    chk("ww_resp", 32'(rl), 32'd0);
    xfer(1'b0, 1'b0, 3'd2, 32'h008, 32'h0, rd, wt, r0, rl);
    chk("wr_waits", 32'(wt), 32'd1);
    chk("wr_resp", 32'(rl), 32'd0);
    chk("wr_data", rd, 32'h12345678);

    // Byte and halfword lane merge
    xfer(1'b0, 1'b1, 3'd2, 32'h010, 32'hAABBCCDD, rd, wt, r0, rl);
    xfer(1'b0, 1'b1, 3'd0, 32'h011, 32'h00001100, rd, wt, r0, rl);
    xfer(1'b0, 1'b1, 3'd1, 32'h012, 32'h22330000, rd, wt, r0, rl);
    xfer(1'b0, 1'b0, 3'd2, 32'h010, 32'h0, rd, wt, r0, rl);
    chk("merge_data", rd, 32'h223311DD);

    // Error responses
    xfer(1'b0, 1'b0, 3'd2, 32'h040, 32'h0, rd, wt, r0, rl);
    chk("err_range_waits", 32'(wt), 32'd1);
    chk("err_range_resp0", 32'(r0), 32'd1);
    chk("err_range_resp1", 32'(rl), 32'd1);
    chk("err_range_rdata", rd, 32'h0);
    xfer(1'b0, 1'b1, 3'd2, 32'h000, 32'h55667788, rd, wt, r0, rl);
    xfer(1'b0, 1'b1, 3'd1, 32'h003, 32'hFFFFFFFF, rd, wt, r0, rl);
    chk("err_align_waits", 32'(wt), 32'd1);
    chk("err_align_resp0", 32'(r0), 32'd1);
    chk("err_align_resp1", 32'(rl), 32'd1);
    xfer(1'b0, 1'b1, 3'd3, 32'h000, 32'hFFFFFFFF, rd, wt, r0, rl);
    chk("err_size_resp1", 32'(rl), 32'd1);
    xfer(1'b0, 1'b0, 3'd2, 32'h000, 32'h0, rd, wt, r0, rl);
    chk("err_mem_unchanged", rd, 32'h55667788);

    // Pipelined write then read, zero wait states
    hsel_w0 = 1'b1; haddr = 32'h000; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
    @(posedge hclk); #1;
    hwdata = 32'hCAFEF00D; haddr = 32'h000; hwrite = 1'b0;
    chk("pipe_w_hready", 32'(hready_w0), 32'd1);
    chk("pipe_w_hresp", 32'(hresp_w0), 32'd0);
    @(posedge hclk); #1;
    hsel_w0 = 1'b0; htrans = 2'b00;
    chk("pipe_r_hready", 32'(hready_w0), 32'd1);
    chk("pipe_r_hresp", 32'(hresp_w0), 32'd0);
    chk("pipe_r_data", hrdata_w0, 32'hCAFEF00D);
    $display("pipelined write/read rdata=%h", hrdata_w0);
    @(posedge hclk); #1;
    chk("pipe_idle_hrdata", hrdata_w0, 32'h0);

    // Doorbell: set, byte write to another lane keeps it, clear
    xfer(1'b0, 1'b1, 3'd2, 32'h03C, 32'h1, rd, wt, r0, rl);
    @(posedge hclk); #1;
    chk("db2_intr_set", 32'(intr_w1), 32'd1);
    xfer(1'b0, 1'b1, 3'd0, 32'h03D, 32'h0000FF00, rd, wt, r0, rl);
    @(posedge hclk); #1;
    chk("db_byte_keeps_intr", 32'(intr_w1), 32'd1);
    xfer(1'b0, 1'b1, 3'd2, 32'h03C, 32'h0, rd, wt, r0, rl);
    @(posedge hclk); #1;
    chk("db_intr_clear", 32'(intr_w1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
